// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback control
// with program counter, instruction register and retired-instruction count.
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] insn_in,
    input  logic       mem_ready,
    input  logic       is_mem_op,
    input  logic       is_store,
    input  logic       needs_wb,
    input  logic       halt_op,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic [2:0] state,
    output logic       mem_req,
    output logic       reg_write_en,
    output logic       mem_write_en,
    output logic       halted,
    output logic [7:0] insn_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_HALT   = 3'b110
    } state_t;

    state_t     state_r;
    logic [7:0] pc_r;
    logic [7:0] ir_r;
    logic [7:0] count_r;

    assign state      = state_r;
    assign pc         = pc_r;
    assign ir         = ir_r;
    assign insn_count = count_r;

    // Sequencer state, PC, IR and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= 8'h00;
            count_r <= 8'h00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= run ? S_FETCH : S_IDLE;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_r    <= insn_in;
                        pc_r    <= pc_r + 8'd1;
                        state_r <= S_DECODE;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (halt_op) begin
                        count_r <= count_r + 8'd1;
                        state_r <= S_HALT;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Branch target loads even when the instruction continues to MEM/WB
                    if (branch_taken) begin
                        pc_r <= branch_target;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (is_mem_op) begin
                        state_r <= S_MEM;
                    end else if (needs_wb) begin
                        state_r <= S_WB;
                    end else begin
                        count_r <= count_r + 8'd1;
                        state_r <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_MEM: begin
                    if (!mem_ready) begin
                        state_r <= S_MEM;
                    end else if (needs_wb) begin
                        state_r <= S_WB;
                    end else begin
                        count_r <= count_r + 8'd1;
                        state_r <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_WB: begin
                    count_r <= count_r + 8'd1;
                    state_r <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    state_r <= run ? S_HALT : S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Memory/register strobes, forced low while reset is asserted
    always_comb begin
        mem_req      = 1'b0;
        reg_write_en = 1'b0;
        mem_write_en = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            mem_req = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: mem_req = 1'b1;
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_write_en = is_store & mem_ready;
                end
                S_WB:    reg_write_en = 1'b1;
                S_HALT:  halted = 1'b1;
                default: mem_req = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port run, input, 1 bit: start or continue instruction sequencing.
REQ-005 SHALL have port insn_in, input, 8 bits: instruction byte from RAM port 1.
REQ-006 SHALL have port mem_ready, input, 1 bit: RAM completes the current request this cycle.
REQ-007 SHALL have ports is_mem_op, is_store, needs_wb and halt_op, all inputs, 1 bit each, decoded combinationally from ir by control.
REQ-008 SHALL have ports branch_taken, input, 1 bit, and branch_target, input, 8 bits: ALU branch decision and target.
REQ-009 SHALL have port pc, output, 8 bits: program counter, drives the RAM port 1 address.
REQ-010 SHALL have port ir, output, 8 bits: instruction register.
REQ-011 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-012 SHALL have ports mem_req, reg_write_en, mem_write_en and halted, all outputs, 1 bit each.
REQ-013 SHALL have port insn_count, output, 8 bits: count of retired instructions.

Function
REQ-014 SHALL implement states IDLE=000, FETCH=001, DECODE=010, EXEC=011, MEM=100, WB=101, HALT=110; codes 111 SHALL go to IDLE next cycle.
REQ-015 IDLE: run=1 -> FETCH; otherwise stay.
REQ-016 FETCH: mem_req=1; on mem_ready=1, ir<=insn_in, pc<=pc+1 (mod 256, 8'hFF->8'h00), -> DECODE; otherwise hold pc/ir and stay.
REQ-017 DECODE: exactly one cycle; halt_op=1 -> HALT, else -> EXEC.
REQ-018 EXEC: exactly one cycle; branch_taken=1 -> pc<=branch_target on exit.
REQ-019 EXEC next state: is_mem_op -> MEM; else needs_wb -> WB; else end of instruction.
REQ-020 Branch and memory op together: pc SHALL still load branch_target, and flow SHALL follow REQ-019.
REQ-021 MEM: mem_req=1; mem_write_en = is_store & mem_ready.
REQ-022 MEM on mem_ready=1: needs_wb -> WB, else end of instruction; otherwise stay.
REQ-023 WB: reg_write_en=1 for exactly one cycle, then end of instruction.
REQ-024 End of instruction: insn_count<=insn_count+1 (mod 256); next state is FETCH if run=1, else IDLE.
REQ-025 run deasserted mid-instruction SHALL NOT abort it; the instruction SHALL complete per REQ-024.
REQ-026 HALT: halted=1; insn_count SHALL increment once on entry.
REQ-027 HALT: stay while run=1; run=0 -> IDLE.
REQ-028 mem_req, reg_write_en and mem_write_en SHALL be combinational from state and inputs and SHALL be 0 in all states not listed above.
REQ-029 halted SHALL be 1 only in HALT.
REQ-030 pc SHALL change only in FETCH (REQ-016) and EXEC (REQ-018); ir SHALL change only in FETCH.

Reset
REQ-031 rst=1 at a clock edge SHALL force state=IDLE, pc=RESET_PC, ir=8'h00 and insn_count=8'h00, regardless of current state, including mid-FETCH or mid-MEM with mem_ready pending.
REQ-032 During and after reset until the next transition: mem_req=0, reg_write_en=0, mem_write_en=0, halted=0.

Verification
REQ-033 ALU-with-writeback: reset, run=1, mem_ready=1, insn_in=8'h21, needs_wb=1 -> states 001,010,011,101,001; pc 00->01; reg_write_en high in WB only; insn_count=1.
REQ-034 Fetch stall: mem_ready=0 for 3 cycles in FETCH -> state stays 001, pc and ir unchanged, mem_req=1 throughout; advances on the cycle mem_ready=1.
REQ-035 Store with branch: is_mem_op=1, is_store=1, branch_taken=1, branch_target=8'h40, mem_ready=1 in MEM -> pc=8'h40 after EXEC; mem_write_en one cycle; then FETCH.
REQ-036 Halt and wrap: pc=8'hFF and halt_op fetched -> pc=8'h00, HALT, halted=1; run=0 -> IDLE.
REQ-037 Mid-op control: run=0 during EXEC -> instruction completes, then IDLE; rst=1 in MEM -> next cycle IDLE, pc=RESET_PC, insn_count=0.
